alu_issue_stage: RTL
====================

# alu_issue_stage

Registered issue/writeback stage wrapped around the combinational `alu_advanced` datapath. It accepts ALU commands over a valid/ready handshake and drives registered operands, opcode and carry-in into the ALU. It captures `Result`/`Flags` into a one-entry response register and maintains the architectural status-flag register. Carry-in can come from the stored C flag, with forwarding, so that back-to-back RCL/RCR chains work at one operation per cycle.

## Interface
- `DATA_W`, 32: operand/result width. Must match `alu_advanced`.
- `OPC_W`, 5: opcode width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_opcode` input OPC_W: ALU opcode, passed through unmodified (e.g. ROL=01011, ROR=01100, RCL=01101, RCR=01110).
- `cmd_a`, `cmd_b` input DATA_W: operands.
- `cmd_cin_sel` input 2: carry-in source. 00 → 0; 01 → 1; 10 → stored C; 11 → inverted stored C.
- `cmd_setflags` input 1: the completed operation writes `status_flags`.
- `alu_a`, `alu_b` output DATA_W: registered operands to the ALU.
- `alu_opcode` output OPC_W: registered opcode to the ALU.
- `alu_cin` output 1: registered carry-in to the ALU.
- `alu_result` input DATA_W: ALU `Result`, combinational from the `alu_*` outputs.
- `alu_flags` input 4: ALU `Flags` {V,C,N,Z}. C is bit 2.
- `rsp_valid` output 1: response held.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_result` output DATA_W: captured result.
- `rsp_flags` output 4: captured {V,C,N,Z}.
- `status_flags` output 4: architectural {V,C,N,Z} register.
- `status_clr` input 1: synchronous clear of `status_flags`.
- `op_count` output 16: completed-operation counter. Wraps at 0xFFFF → 0.

## Operation
- The block has two stages:
  - EX: `ex_valid` plus the `alu_*` registers.
  - WB: `rsp_valid` plus the `rsp_*` registers.
- Each stage is either empty or full. Legal states are {EX empty, WB empty}, {EX full, WB empty}, {EX empty, WB full} and {EX full, WB full}.
- `wb_free = !rsp_valid || rsp_ready`.
- `ex_adv = ex_valid && wb_free`.
- `cmd_ready = !ex_valid || wb_free`. It is combinational and is 1 out of reset.
- On command accept:
  - Load `alu_a`, `alu_b` and `alu_opcode`.
  - Set `ex_valid`.
  - Load `alu_cin` from `cmd_cin_sel`.
- Carry forwarding applies when `cmd_cin_sel` is 1x, the instruction leaving EX this cycle (`ex_adv`) has setflags=1, and `status_clr` is 0.
  - In that case the C source is `alu_flags[2]`, not `status_flags[2]`.
  - If `status_clr` is 1 in that cycle, the C source is 0.
- On `ex_adv`:
  - `rsp_result` ← `alu_result`.
  - `rsp_flags` ← `alu_flags`.
  - `rsp_valid` ← 1.
  - `op_count` increments.
  - If that op has setflags=1, `status_flags` ← `alu_flags`.
  - `ex_valid` is cleared unless a new command is accepted in the same cycle.
- `rsp_valid` clears when `rsp_ready && rsp_valid && !ex_adv`.
- `status_clr` takes priority over a simultaneous flag write. `status_flags` ← 0000.
- No checking of opcode legality. Unknown opcodes complete normally with whatever the ALU returns.
- Asynchronous reset mid-operation drops all in-flight commands and responses.

## Timing
- Reset values: `alu_a`, `alu_b`, `alu_opcode`, `alu_cin`, `rsp_result`, `rsp_flags`, `status_flags` and `op_count` are all 0. `rsp_valid` = 0. `ex_valid` = 0.
- A command accepted at edge N drives the ALU from edge N.
- Its response is valid after edge N+1, so latency is 2 edges.
- Throughput is 1 op/cycle while `rsp_ready` = 1.
- When `rsp_valid` = 1 and `rsp_ready` = 0:
  - WB holds its contents stable.
  - EX holds its contents stable.
  - `cmd_ready` drops once EX is full.
  - No data is lost or duplicated.
- `status_flags` updates at the same edge at which `rsp_valid` rises for that op.
- A dependent command (cin_sel=10) issued immediately after a setflags op needs no bubble, because the forwarded C is used.

## Test plan
- Reset, then check outputs.
  - Stimulus: hold `rst_n`=0, then release.
  - Required: all outputs 0, `cmd_ready`=1, `rsp_valid`=0.
  - Stimulus: assert `rst_n` low mid-stall.
  - Required: everything returns to 0 immediately, with no clock needed.
- Single ROL.
  - Stimulus: A=0x80000000, B=1, opcode=01011, sel=00, setflags=1.
  - Required: `rsp_result`=0x00000001, valid 2 edges after accept. `op_count`=1.
- Forwarded RCL chain.
  - Stimulus: RCL A=0x80000000 B=1 sel=00 setflags=1, then next cycle RCL A=0 B=1 sel=10.
  - Required: first result 0x00000000 with C=1. Second `alu_cin`=1 and result 0x00000001, with no bubble.
- Inverted carry on RCR.
  - Stimulus: `status_flags` C=1, then RCR A=0 B=1 sel=11.
  - Required: `alu_cin`=0, result 0x00000000.
  - Stimulus: sel=01.
  - Required: result 0x80000000.
- Backpressure.
  - Stimulus: stream 4 ROR commands (A=2,4,8,16, B=1) with `rsp_ready` low for 3 cycles.
  - Required: `cmd_ready` drops after 2 accepts. Responses come out 1,2,4,8 in order with no loss. `op_count`=4.
- Clear collision.
  - Stimulus: `status_clr`=1 on the same edge a setflags op completes, with a sel=10 command accepted.
  - Required: `status_flags`=0000 and forwarded cin=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Registered issue (EX) and writeback (WB) stage around the combinational alu_advanced datapath.
// Holds the architectural status flags and forwards C so carry chains need no bubbles.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OPC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  // Command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [1:0]        cmd_cin_sel,
  input  logic              cmd_setflags,
  // ALU drive and return
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  // Status
  output logic [3:0]        status_flags,
  input  logic              status_clr,
  output logic [15:0]       op_count
);

  localparam int unsigned FlagC = 2;

  // EX stage
  logic              ex_valid_q, ex_valid_d;
  logic              ex_setflags_q, ex_setflags_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
  logic              alu_cin_q, alu_cin_d;

  // WB stage and architectural state
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [3:0]        status_q, status_d;
  logic [15:0]       op_count_q, op_count_d;

  logic wb_free;
  logic ex_adv;
  logic cmd_acc;
  logic ex_writes_flags;
  logic carry_src;
  logic sel_cin;

  // Handshake
  always_comb begin
    wb_free         = !rsp_valid_q || rsp_ready;
    ex_adv          = ex_valid_q && wb_free;
    cmd_ready       = !ex_valid_q || wb_free;
    cmd_acc         = cmd_valid && cmd_ready;
    ex_writes_flags = ex_adv && ex_setflags_q;
  end

  // Carry source is the C value status_flags will hold after this edge, so a dependent
  // command sees the result of the op retiring in the same cycle.
  always_comb begin
    carry_src = status_q[FlagC];
    if (status_clr) begin
      carry_src = 1'b0;
    end else if (ex_writes_flags) begin
      carry_src = alu_flags[FlagC];
    end
  end

  always_comb begin
    sel_cin = 1'b0;
    case (cmd_cin_sel)
      2'b00:   sel_cin = 1'b0;
      2'b01:   sel_cin = 1'b1;
      2'b10:   sel_cin = carry_src;
      default: sel_cin = ~carry_src;
    endcase
  end

  // EX next state
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_setflags_d = ex_setflags_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_opcode_d  = alu_opcode_q;
    alu_cin_d     = alu_cin_q;
    if (cmd_acc) begin
      ex_valid_d    = 1'b1;
      ex_setflags_d = cmd_setflags;
      alu_a_d       = cmd_a;
      alu_b_d       = cmd_b;
      alu_opcode_d  = cmd_opcode;
      alu_cin_d     = sel_cin;
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end
  end

  // WB next state
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    op_count_d   = op_count_q;
    if (ex_adv) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
      op_count_d   = op_count_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Clear wins over a simultaneous flag write
  always_comb begin
    status_d = status_q;
    if (status_clr) begin
      status_d = 4'b0000;
    end else if (ex_writes_flags) begin
      status_d = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_setflags_q <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_opcode_q  <= '0;
      alu_cin_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= 4'b0000;
      status_q      <= 4'b0000;
      op_count_q    <= 16'd0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_setflags_q <= ex_setflags_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_cin_q     <= alu_cin_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      status_q      <= status_d;
      op_count_q    <= op_count_d;
    end
  end

  always_comb begin
    alu_a        = alu_a_q;
    alu_b        = alu_b_q;
    alu_opcode   = alu_opcode_q;
    alu_cin      = alu_cin_q;
    rsp_valid    = rsp_valid_q;
    rsp_result   = rsp_result_q;
    rsp_flags    = rsp_flags_q;
    status_flags = status_q;
    op_count     = op_count_q;
  end

endmodule
